pc_fetch_sequencer: RTL
=======================

# pc_fetch_sequencer

Fetch-stage controller that sequences the 32-bit PC register of the MIPS32 core and owns the instruction-memory handshake. Every cycle it computes the next PC value from the sequential path, branch, jump, exception vector or exception return. It drives that value into the PC register's input, which loads unconditionally each clock. A single-entry output register presents fetched instructions to decode under a stall-based backpressure rule. Redirects arriving while a memory access is outstanding are deferred and the stale fetch is squashed.

## Interface
- RESET_PC, 32'h0000_0000: value forced into the PC register during BOOT; must equal the PC register's reset value.
- EXC_VECTOR, 32'h0000_0080: exception handler address.
- Clk  in  1  clock, rising edge.
- Rst  in  1  reset; asynchronous and active-high.
- pc_in  in  32  current PC (PC register output).
- pc_next  out  32  next PC (PC register input).
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, always equal to pc_in.
- imem_ready  in  1  memory completes the access this cycle.
- imem_rdata  in  32  instruction word, valid with imem_ready.
- stall  in  1  decode cannot accept the presented instruction.
- branch_taken  in  1  branch redirect.
- branch_target  in  32  branch target.
- jump  in  1  jump redirect.
- jump_target  in  32  jump target.
- exception  in  1  exception redirect.
- exc_pc  in  32  faulting PC to save.
- eret  in  1  return from exception.
- instr_valid  out  1  instr/instr_pc hold a live instruction.
- instr  out  32  fetched instruction.
- instr_pc  out  32  address of instr.
- epc  out  32  saved exception PC.
- exc_active  out  1  handler in progress.

## Operation
- Reset state: BOOT. Output reset values: instr_valid 0, instr 0, instr_pc 0, epc 0, exc_active 0, imem_req 0.
- pc_next = pc_in in every cycle unless a rule below sets it.
- Completion is defined as a cycle with imem_req & imem_ready.
- slot_free = !instr_valid | !stall.
- Consumption is defined as a cycle with instr_valid & !stall. On consumption, instr_valid clears unless the same cycle refills it.
- Redirect sources, in priority order:
  - exception: target EXC_VECTOR.
  - eret, only when exc_active = 1: target epc.
  - jump: target jump_target.
  - branch_taken: target branch_target.
- eret with exc_active = 0 is ignored.
- All targets have bits [1:0] forced to 0. Sequential PC is pc_in + 4, wrapping modulo 2^32.
- Any redirect squashes the slot: instr_valid <= 0, including when the slot is consumed in the same cycle.
- exception: epc <= exc_pc and exc_active <= 1 only if exc_active was 0. A nested exception still redirects but keeps epc.
- Accepted eret: exc_active <= 0.
- States:
  - BOOT: imem_req 0, pc_next = RESET_PC; redirects ignored. Next state ISSUE.
  - ISSUE, redirect present: imem_req 0, pc_next = target; stay in ISSUE.
  - ISSUE, no redirect: imem_req = slot_free.
    - On completion: instr <= imem_rdata, instr_pc <= pc_in, instr_valid <= 1, pc_next = pc_in + 4; stay in ISSUE.
    - Request raised without imem_ready: go to WAIT.
  - WAIT: imem_req 1, address stable.
    - Completion, no redirect: capture as in ISSUE, then go to ISSUE.
    - Completion with redirect: discard data, pc_next = target, then go to ISSUE.
    - Redirect without completion: latch target into redir_pc, then go to DRAIN.
  - DRAIN: imem_req 1, pc_next = pc_in.
    - A new redirect overwrites redir_pc.
    - On completion: discard data; pc_next = same-cycle redirect target if present, else redir_pc; then go to ISSUE.
- Requests are issued only when the slot will be empty, so completion data always has room. No skid buffer exists.

## Timing
- From Rst deassertion: cycle 0 is BOOT. The first request (address RESET_PC) is in cycle 1.
- With a zero-wait memory and no stall, one instruction is fetched per cycle.
  - instr_valid rises the cycle after completion.
  - pc_in advances the cycle after completion.
- A redirect in ISSUE: fetch of the target starts the next cycle (one bubble).
- A redirect in WAIT or DRAIN: the target fetch starts the cycle after the outstanding completion.
- Once raised, imem_req stays high with a stable address until completion. stall never drops it.
- Asynchronous Rst at any point returns all state and outputs to reset values immediately. The in-flight access is abandoned; the memory must also be reset.
- All outputs except imem_req, pc_next and imem_addr are registered.

## Test plan
- Rst pulse, zero-wait memory: cycle 1 request to 0x0, then 0x4, 0x8, 0xC on consecutive cycles; instr_valid rises in cycle 2 with instr_pc 0x0.
- imem_ready low for 2 cycles at 0x4: imem_req and imem_addr 0x4 held, pc_next = 0x4; on completion instr_pc = 0x4, then a request to 0x8.
- stall high 3 cycles with instr_pc 0x8 valid: instr stable, imem_req 0, pc_in stays 0xC; stall drop → request 0xC the same cycle.
- branch_taken target 0x43 while waiting on 0x10: state DRAIN; data for 0x10 never becomes valid; next request 0x40.
- Exception sequence:
  - exception with exc_pc 0x24: next request 0x80, epc 0x24, exc_active 1.
  - exception with exc_pc 0x90: epc remains 0x24.
  - eret: request 0x24, exc_active 0.
  - second eret: no redirect.
- Rst asserted mid-WAIT: instr_valid, imem_req and exc_active drop before the next edge; BOOT resumes and the first request is 0x0.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// Fetch-stage controller for the MIPS32 core: computes the next PC, drives the
// instruction-memory handshake and holds one fetched instruction for decode.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    output logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        exception,
    input  logic [31:0] exc_pc,
    input  logic        eret,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] epc,
    output logic        exc_active
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        eret_ok;
    logic        redirect;
    logic        slot_free;
    logic        capture;
    logic        squash;
    logic        active;
    logic [31:0] target_raw;
    logic [31:0] target;
    logic [31:0] seq_pc;
    logic [31:0] redir_pc;
    logic [31:0] redir_pc_nxt;

    assign imem_addr = pc_in;
    assign seq_pc    = pc_in + 32'd4;
    assign slot_free = ~instr_valid | ~stall;
    assign active    = (state != BOOT);

    // Redirect detection and priority selection of the redirect target.
    always_comb begin
        eret_ok  = eret & exc_active;
        redirect = exception | eret_ok | jump | branch_taken;
        if (exception) begin
            target_raw = EXC_VECTOR;
        end else if (eret_ok) begin
            target_raw = epc;
        end else if (jump) begin
            target_raw = jump_target;
        end else begin
            target_raw = branch_target;
        end
        target = {target_raw[31:2], 2'b00};
    end

    // Next-state, request and next-PC selection.
    always_comb begin
        state_nxt    = state;
        pc_next      = pc_in;
        imem_req     = 1'b0;
        capture      = 1'b0;
        squash       = 1'b0;
        redir_pc_nxt = redir_pc;
        case (state)
            BOOT: begin
                pc_next   = RESET_PC;
                state_nxt = ISSUE;
            end
            ISSUE: begin
                if (redirect) begin
                    pc_next = target;
                    squash  = 1'b1;
                end else begin
                    imem_req = slot_free;
                    if (slot_free & imem_ready) begin
                        capture = 1'b1;
                        pc_next = seq_pc;
                    end else if (slot_free) begin
                        state_nxt = WAIT;
                    end else begin
                        state_nxt = ISSUE;
                    end
                end
            end
            WAIT: begin
                imem_req = 1'b1;
                squash   = redirect;
                if (imem_ready) begin
                    state_nxt = ISSUE;
                    if (redirect) begin
                        pc_next = target;
                    end else begin
                        capture = 1'b1;
                        pc_next = seq_pc;
                    end
                end else if (redirect) begin
                    redir_pc_nxt = target;
                    state_nxt    = DRAIN;
                end else begin
                    state_nxt = WAIT;
                end
            end
            DRAIN: begin
                // The stale access must finish before the deferred target is fetched.
                imem_req = 1'b1;
                squash   = redirect;
                if (redirect) begin
                    redir_pc_nxt = target;
                end else begin
                    redir_pc_nxt = redir_pc;
                end
                if (imem_ready) begin
                    pc_next   = redirect ? target : redir_pc;
                    state_nxt = ISSUE;
                end else begin
                    state_nxt = DRAIN;
                end
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    // State, decode slot and exception bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BOOT;
            redir_pc    <= 32'h0000_0000;
            instr_valid <= 1'b0;
            instr       <= 32'h0000_0000;
            instr_pc    <= 32'h0000_0000;
            epc         <= 32'h0000_0000;
            exc_active  <= 1'b0;
        end else begin
            state    <= state_nxt;
            redir_pc <= redir_pc_nxt;
            if (capture) begin
                instr       <= imem_rdata;
                instr_pc    <= pc_in;
                instr_valid <= 1'b1;
            end else if (squash | (instr_valid & ~stall)) begin
                instr_valid <= 1'b0;
            end
            // A nested exception keeps the original return address.
            if (active & exception) begin
                if (!exc_active) begin
                    epc        <= exc_pc;
                    exc_active <= 1'b1;
                end
            end else if (active & eret_ok) begin
                exc_active <= 1'b0;
            end
        end
    end

endmodule
